// File: rtl/core_boot_sequencer_if.sv
// rtl/core_boot_sequencer_if.sv - network packet types and the boot sequencer's ROM/dmem/network bus
package core_boot_sequencer_pkg;
    localparam logic [2:0] OP_NULL  = 3'd0;
    localparam logic [2:0] OP_INSTR = 3'd1;
    localparam logic [2:0] OP_REG   = 3'd2;
    localparam logic [2:0] OP_BAR   = 3'd3;
    localparam logic [2:0] OP_PC    = 3'd4;

    typedef struct packed {
        logic [2:0]  net_op;
        logic [9:0]  net_id;
        logic [9:0]  net_addr;
        logic [31:0] net_data;
    } net_packet_s;
endpackage

interface core_boot_sequencer_if;
    logic [9:0]                           img_addr_o;
    logic [1:0]                           img_sel_o;
    logic [39:0]                          img_data_i;
    logic                                 dmem_valid_o;
    logic [31:0]                          dmem_addr_o;
    logic [31:0]                          dmem_wdata_o;
    logic                                 dmem_ready_i;
    core_boot_sequencer_pkg::net_packet_s net_packet_o;

    modport master (
        output img_addr_o, img_sel_o, dmem_valid_o, dmem_addr_o, dmem_wdata_o, net_packet_o,
        input  img_data_i, dmem_ready_i
    );

    modport slave (
        input  img_addr_o, img_sel_o, dmem_valid_o, dmem_addr_o, dmem_wdata_o, net_packet_o,
        output img_data_i, dmem_ready_i
    );
endinterface

// File: rtl/core_boot_sequencer.sv
// rtl/core_boot_sequencer.sv - boot engine: data image into dmem, instr/reg images to the core as packets
module core_boot_sequencer
    import core_boot_sequencer_pkg::*;
#(
    parameter int          DATA_DEPTH_P  = 1024,
    parameter int          INSTR_DEPTH_P = 1024,
    parameter int          REG_DEPTH_P   = 64,
    parameter logic [9:0]  CORE_ID_P     = 10'h001,
    parameter logic [9:0]  BAR_ADDR_P    = 10'd24,
    parameter logic [31:0] BAR_MASK_P    = 32'h2,
    parameter logic [31:0] START_PC_P    = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    core_boot_sequencer_if.master bus,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int DW = $clog2(DATA_DEPTH_P) + 1;
    localparam int IW = $clog2(INSTR_DEPTH_P) + 1;
    localparam int RW = $clog2(REG_DEPTH_P) + 1;

    localparam logic [DW-1:0] D_LAST = DW'(DATA_DEPTH_P - 1);
    localparam logic [IW-1:0] I_LAST = IW'(INSTR_DEPTH_P - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REG_DEPTH_P - 1);

    localparam logic [1:0] SEL_DATA  = 2'd0;
    localparam logic [1:0] SEL_INSTR = 2'd1;
    localparam logic [1:0] SEL_REG   = 2'd2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DMEM  = 3'd1;
    localparam logic [2:0] S_INSTR = 3'd2;
    localparam logic [2:0] S_REG   = 3'd3;
    localparam logic [2:0] S_BAR   = 3'd4;
    localparam logic [2:0] S_PC    = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam net_packet_s IDLE_PKT = {OP_NULL, CORE_ID_P, 10'd0, 32'd0};
    localparam net_packet_s DONE_PKT = {OP_NULL, CORE_ID_P, BAR_ADDR_P, 32'hFFFF_FFFE};

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] d_cnt_q, d_cnt_d;
    logic [IW-1:0] i_cnt_q, i_cnt_d;
    logic [RW-1:0] r_cnt_q, r_cnt_d;
    logic          pend_q, pend_d;
    net_packet_s   pkt_q, pkt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          d_take;
    logic [9:0]    img_addr;
    logic [1:0]    img_sel;
    logic          unused_img_bits;

    // pend_q: the word at the phase counter is on img_data_i this cycle.
    // The issued address is whichever word is needed next cycle, so a stalled
    // write re-reads its own word and the last element issues the next phase.
    always_comb begin
        state_d  = state_q;
        d_cnt_d  = d_cnt_q;
        i_cnt_d  = i_cnt_q;
        r_cnt_d  = r_cnt_q;
        pend_d   = 1'b0;
        pkt_d    = IDLE_PKT;
        busy_d   = busy_q;
        done_d   = done_q;
        d_take   = 1'b0;
        img_addr = 10'd0;
        img_sel  = SEL_DATA;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DMEM;
                    busy_d  = 1'b1;
                end
            end
            S_DMEM: begin
                pend_d   = 1'b1;
                d_take   = pend_q && bus.dmem_ready_i;
                img_addr = 10'(d_cnt_q);
                if (d_take) begin
                    if (d_cnt_q == D_LAST) begin
                        state_d  = S_INSTR;
                        img_sel  = SEL_INSTR;
                        img_addr = 10'd0;
                    end else begin
                        d_cnt_d  = d_cnt_q + DW'(1);
                        img_addr = 10'(d_cnt_d);
                    end
                end
            end
            S_INSTR: begin
                pend_d   = 1'b1;
                img_sel  = SEL_INSTR;
                img_addr = 10'(i_cnt_q);
                if (pend_q) begin
                    pkt_d = {OP_INSTR, CORE_ID_P, 10'(i_cnt_q), 16'd0, bus.img_data_i[15:0]};
                    if (i_cnt_q == I_LAST) begin
                        state_d  = S_REG;
                        img_sel  = SEL_REG;
                        img_addr = 10'd0;
                    end else begin
                        i_cnt_d  = i_cnt_q + IW'(1);
                        img_addr = 10'(i_cnt_d);
                    end
                end
            end
            S_REG: begin
                pend_d   = 1'b1;
                img_sel  = SEL_REG;
                img_addr = 10'(r_cnt_q);
                if (pend_q) begin
                    pkt_d = {OP_REG, CORE_ID_P, 4'd0, bus.img_data_i[37:32], bus.img_data_i[31:0]};
                    if (r_cnt_q == R_LAST) begin
                        state_d  = S_BAR;
                        pend_d   = 1'b0;
                        img_addr = 10'd0;
                    end else begin
                        r_cnt_d  = r_cnt_q + RW'(1);
                        img_addr = 10'(r_cnt_d);
                    end
                end
            end
            S_BAR: begin
                pkt_d   = {OP_BAR, CORE_ID_P, BAR_ADDR_P, BAR_MASK_P};
                state_d = S_PC;
            end
            S_PC: begin
                pkt_d   = {OP_PC, CORE_ID_P, 10'd0, START_PC_P};
                state_d = S_DONE;
            end
            S_DONE: begin
                pkt_d  = DONE_PKT;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            d_cnt_q <= '0;
            i_cnt_q <= '0;
            r_cnt_q <= '0;
            pend_q  <= 1'b0;
            pkt_q   <= IDLE_PKT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_cnt_q <= d_cnt_d;
            i_cnt_q <= i_cnt_d;
            r_cnt_q <= r_cnt_d;
            pend_q  <= pend_d;
            pkt_q   <= pkt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.img_addr_o   = img_addr;
    assign bus.img_sel_o    = img_sel;
    assign bus.dmem_valid_o = (state_q == S_DMEM) && pend_q;
    assign bus.dmem_addr_o  = {30'(d_cnt_q), 2'b00};
    assign bus.dmem_wdata_o = bus.img_data_i[31:0];
    assign bus.net_packet_o = pkt_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign unused_img_bits  = ^bus.img_data_i[39:38];
endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb/tb_core_boot_sequencer.sv - two sequencer configs under random stimulus vs a transaction-timing model
module tb_core_boot_sequencer;
    import core_boot_sequencer_pkg::*;

    logic clk, reset, start, ready;
    int   n_vec = 0;
    int   n_err = 0;
    int   rel   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic net_packet_s mkpkt(input logic [2:0] op, input logic [9:0] addr,
                                          input logic [31:0] data);
        net_packet_s p;
        p.net_op   = op;
        p.net_id   = 10'h001;
        p.net_addr = addr;
        p.net_data = data;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gcfg
        localparam int          D   = (g == 0) ? 4 : 1;
        localparam int          I   = (g == 0) ? 3 : 1;
        localparam int          R   = (g == 0) ? 2 : 1;
        localparam logic [31:0] PC0 = (g == 0) ? 32'h0000_1000 : 32'h0;

        core_boot_sequencer_if bus ();
        logic        busy_w, done_w;
        logic [39:0] rom [4][1024];

        core_boot_sequencer #(
            .DATA_DEPTH_P (D),
            .INSTR_DEPTH_P(I),
            .REG_DEPTH_P  (R),
            .START_PC_P   (PC0)
        ) dut (
            .clk    (clk),
            .reset  (reset),
            .start_i(start),
            .bus    (bus),
            .busy_o (busy_w),
            .done_o (done_w)
        );

        assign bus.dmem_ready_i = ready;
        always @(posedge clk) bus.img_data_i <= rom[bus.img_sel_o][bus.img_addr_o];

        initial begin
            for (int s = 0; s < 4; s++)
                for (int a = 0; a < 1024; a++)
                    rom[s][a] = 40'({$urandom, $urandom});
        end

        // Model: writes are offered every cycle from start+2 until D are accepted;
        // the packet stream starts 2 cycles after the last acceptance, unbroken.
        initial begin : model
            bit          known, booted, exp_valid, exp_done;
            int          mc, mwr, mlast, k, r;
            net_packet_s ep;
            known = 1'b0; booted = 1'b0; mc = 0; mwr = 0; mlast = 0;
            forever begin
                @(negedge clk);
                exp_valid = booted && mc >= 2 && mwr < D;
                k = (booted && mwr == D) ? mc - mlast - 2 : -1;
                r = k - I;
                exp_done = booted && k >= I + R + 2;
                ep = mkpkt(OP_NULL, 10'd0, 32'd0);
                if (k >= 0 && k < I)
                    ep = mkpkt(OP_INSTR, 10'(k), {16'd0, rom[1][k[9:0]][15:0]});
                else if (k >= I && k < I + R)
                    ep = mkpkt(OP_REG, {4'd0, rom[2][r[9:0]][37:32]}, rom[2][r[9:0]][31:0]);
                else if (k == I + R)
                    ep = mkpkt(OP_BAR, 10'd24, 32'h2);
                else if (k == I + R + 1)
                    ep = mkpkt(OP_PC, 10'd0, PC0);
                else if (k > I + R + 1)
                    ep = mkpkt(OP_NULL, 10'd24, 32'hFFFF_FFFE);
                if (known) begin
                    chk($sformatf("cfg%0d dmem_valid", g), 64'(bus.dmem_valid_o), 64'(exp_valid));
                    if (exp_valid) begin
                        chk($sformatf("cfg%0d dmem_addr", g), 64'(bus.dmem_addr_o), 64'(4 * mwr));
                        chk($sformatf("cfg%0d dmem_wdata", g), 64'(bus.dmem_wdata_o),
                            64'(rom[0][mwr[9:0]][31:0]));
                    end
                    chk($sformatf("cfg%0d net_packet", g), 64'(bus.net_packet_o), 64'(ep));
                    chk($sformatf("cfg%0d busy", g), 64'(busy_w), 64'(booted && !exp_done));
                    chk($sformatf("cfg%0d done", g), 64'(done_w), 64'(exp_done));
                end
                if (reset) begin
                    known  = 1'b1;
                    booted = 1'b0;
                end else if (!booted) begin
                    if (start) begin
                        booted = 1'b1;
                        mc     = 1;
                        mwr    = 0;
                    end
                end else begin
                    if (exp_valid && ready) begin
                        mwr++;
                        if (mwr == D) mlast = mc;
                    end
                    mc++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic at(input int c);
        while (rel < c) cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic start_boot();
        start = 1'b1;
        rel   = 0;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to_done(input bit rnd);
        for (int t = 0; t < 400; t++) begin
            if (gcfg[0].done_w && gcfg[1].done_w) break;
            cyc();
            if (rnd) ready = ($urandom_range(0, 3) != 0);
        end
        chk("boot completes", 64'(gcfg[0].done_w && gcfg[1].done_w), 64'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ready = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("reset packet", 64'(gcfg[0].bus.net_packet_o), 64'(mkpkt(OP_NULL, 10'd0, 32'd0)));
        chk("reset busy", 64'(gcfg[0].busy_w), 64'd0);
        chk("reset dmem_valid", 64'(gcfg[1].bus.dmem_valid_o), 64'd0);
        cyc();
        reset = 1'b0;
        cyc();

        // ready held high, start pulse during busy and again in DONE
        start_boot();
        at(1);
        chk("busy after start", 64'(gcfg[0].busy_w), 64'd1);
        chk("no write at +1", 64'(gcfg[0].bus.dmem_valid_o), 64'd0);
        at(2);
        chk("first write at +2", 64'(gcfg[0].bus.dmem_valid_o), 64'd1);
        chk("first addr", 64'(gcfg[0].bus.dmem_addr_o), 64'd0);
        at(3);
        chk("second addr", 64'(gcfg[0].bus.dmem_addr_o), 64'd4);
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        at(5);
        chk("fourth addr", 64'(gcfg[0].bus.dmem_addr_o), 64'd12);
        at(7);
        chk("instr0 op", 64'(gcfg[0].bus.net_packet_o.net_op), 64'(OP_INSTR));
        chk("instr0 addr", 64'(gcfg[0].bus.net_packet_o.net_addr), 64'd0);
        chk("depth1 pc", 64'(gcfg[1].bus.net_packet_o), 64'(mkpkt(OP_PC, 10'd0, 32'h0)));
        chk("depth1 not done", 64'(gcfg[1].done_w), 64'd0);
        at(8);
        chk("instr1 addr", 64'(gcfg[0].bus.net_packet_o.net_addr), 64'd1);
        chk("depth1 done", 64'(gcfg[1].done_w), 64'd1);
        at(12);
        chk("bar packet", 64'(gcfg[0].bus.net_packet_o), 64'(mkpkt(OP_BAR, 10'd24, 32'h2)));
        at(13);
        chk("pc packet", 64'(gcfg[0].bus.net_packet_o), 64'(mkpkt(OP_PC, 10'd0, 32'h1000)));
        chk("not done before null", 64'(gcfg[0].done_w), 64'd0);
        at(14);
        chk("done", 64'(gcfg[0].done_w), 64'd1);
        chk("done packet", 64'(gcfg[0].bus.net_packet_o), 64'(mkpkt(OP_NULL, 10'd24, 32'hFFFF_FFFE)));
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        repeat (5) cyc();

        // ready toggled 1,0,0,1 during DMEM
        do_reset();
        start_boot();
        cyc(); ready = 1'b1;
        cyc(); ready = 1'b0;
        at(3);
        chk("stall addr", 64'(gcfg[0].bus.dmem_addr_o), 64'd4);
        cyc(); ready = 1'b0;
        at(4);
        chk("stall wdata", 64'(gcfg[0].bus.dmem_wdata_o), 64'(gcfg[0].rom[0][1][31:0]));
        cyc(); ready = 1'b1;
        at(6);
        chk("after stall addr", 64'(gcfg[0].bus.dmem_addr_o), 64'd8);
        run_to_done(1'b1);

        // reset mid-INSTR, then reboot from data word 0
        ready = 1'b1;
        do_reset();
        start_boot();
        while (rel < 7) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        at(8);
        chk("abort packet", 64'(gcfg[0].bus.net_packet_o), 64'(mkpkt(OP_NULL, 10'd0, 32'd0)));
        chk("abort no write", 64'(gcfg[0].bus.dmem_valid_o), 64'd0);
        chk("abort busy", 64'(gcfg[0].busy_w), 64'd0);
        cyc();
        start_boot();
        at(2);
        chk("reboot addr", 64'(gcfg[0].bus.dmem_addr_o), 64'd0);
        chk("reboot wdata", 64'(gcfg[0].bus.dmem_wdata_o), 64'(gcfg[0].rom[0][0][31:0]));
        run_to_done(1'b0);

        // random ready, stray starts and occasional mid-boot resets
        for (int b = 0; b < 12; b++) begin
            do_reset();
            start_boot();
            for (int t = 0; t < 400; t++) begin
                cyc();
                ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 7) == 0);
                reset = (t < 40) && ($urandom_range(0, 39) == 0);
                if (t >= 40 && gcfg[0].done_w && gcfg[1].done_w) break;
            end
            start = 1'b0; reset = 1'b0;
            chk("random boot completes", 64'(gcfg[0].done_w && gcfg[1].done_w), 64'd1);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
